// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between instruction fetch
// and load/store. At most one access is outstanding; a new grant may coincide with a response.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [15:0]              contention_cnt
);

  typedef enum logic {S_READY, S_WAIT} state_e;
  typedef enum logic {FETCH, DATA} src_e;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

  state_e      state_q;
  src_e        win_q;
  src_e        rr_last_q;
  logic        we_q;
  logic [2:0]  lat_q;
  logic [15:0] cnt_q;

  logic resp;
  logic slot;
  logic gnt_fetch;
  logic gnt_data;
  logic contend;

  always_comb begin
    resp      = (state_q == S_WAIT) && (lat_q == '0);
    // The response cycle doubles as a grant slot so back-to-back accesses need no bubble.
    slot      = !rst && ((state_q == S_READY) || resp);
    contend   = if_req && d_req;
    gnt_fetch = 1'b0;
    gnt_data  = 1'b0;
    if (slot) begin
      if (contend) begin
        if (rr_last_q == FETCH) gnt_data  = 1'b1;
        else                    gnt_fetch = 1'b1;
      end else begin
        gnt_fetch = if_req;
        gnt_data  = d_req;
      end
    end
  end

  assign if_gnt    = gnt_fetch;
  assign d_gnt     = gnt_data;
  assign mem_req   = gnt_fetch || gnt_data;
  assign mem_we    = gnt_data && d_we;
  assign mem_addr  = gnt_data ? d_addr : (gnt_fetch ? if_addr : '0);
  assign mem_wdata = (gnt_data && d_we) ? d_wdata : '0;

  assign if_rvalid = resp && (win_q == FETCH);
  assign d_rvalid  = resp && (win_q == DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

  assign contention_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_READY;
      win_q     <= FETCH;
      rr_last_q <= FETCH;
      we_q      <= 1'b0;
      lat_q     <= '0;
      cnt_q     <= '0;
    end else begin
      if (gnt_fetch || gnt_data) begin
        state_q <= S_WAIT;
        lat_q   <= LAT_INIT;
        win_q   <= gnt_data ? DATA : FETCH;
        we_q    <= gnt_data && d_we;
        if (contend) rr_last_q <= gnt_data ? DATA : FETCH;
      end else if (resp) begin
        state_q <= S_READY;
      end else if (state_q == S_WAIT) begin
        lat_q <= lat_q - 3'd1;
      end
      if (contend && (cnt_q != '1)) cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at latency 1 and one at latency 3,
// sharing requester stimulus, each with its own behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [11:0] if_addr, d_addr;
  logic [31:0] d_wdata;

  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_req1, mem_we1;
  logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [11:0] mem_addr1;
  logic [15:0] cnt1;

  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_req3, mem_we3;
  logic [31:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [11:0] mem_addr3;
  logic [15:0] cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .MEM_LATENCY(1)) u_arb1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .contention_cnt(cnt1)
  );

  mem_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .MEM_LATENCY(3)) u_arb3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_req(mem_req3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .contention_cnt(cnt3)
  );

  // Background contents: word i holds 0xA000_0000 | i, except word 1 holds an ADDI opcode.
  function automatic logic [31:0] bg_word(input logic [11:0] a);
    logic [9:0] w;
    w = a[11:2];
    if (w == 10'd1) return 32'h0050_0093;
    return 32'hA000_0000 | {22'd0, w};
  endfunction

  // Latency-1 memory with a single writable location (read-before-write).
  logic        wr_valid = 1'b0;
  logic [11:0] wr_addr  = '0;
  logic [31:0] wr_data  = '0;
  logic [31:0] rd1      = '0;
  assign mem_rdata1 = rd1;
  always @(posedge clk) begin
    if (mem_req1)
      rd1 <= (wr_valid && wr_addr[11:2] == mem_addr1[11:2]) ? wr_data : bg_word(mem_addr1);
    else
      rd1 <= '0;
    if (mem_req1 && mem_we1) begin
      wr_valid <= 1'b1;
      wr_addr  <= mem_addr1;
      wr_data  <= mem_wdata1;
    end
  end

  // Latency-3 read-only memory; pipeline keeps running through reset.
  logic [31:0] p0 = '0, p1 = '0, p2 = '0;
  assign mem_rdata3 = p2;
  always @(posedge clk) begin
    p0 <= mem_req3 ? bg_word(mem_addr3) : '0;
    p1 <= p0;
    p2 <= p1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Asynchronous reset while both requesters are active
    if_req = 1; d_req = 1; if_addr = 12'h008; d_addr = 12'h00C;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_if_gnt",   32'(if_gnt1), 0);
    check("rst_d_gnt",    32'(d_gnt1), 0);
    check("rst_mem_req",  32'(mem_req1), 0);
    check("rst_mem_addr", 32'(mem_addr1), 0);
    check("rst_rvalid",   32'({if_rvalid1, d_rvalid1}), 0);
    check("rst_cnt",      32'(cnt1), 0);
    if_req = 0; d_req = 0;
    step(); rst = 1'b0;

    // Single fetch, latency 1
    if_req = 1; if_addr = 12'h004;
    @(negedge clk);
    check("sf_if_gnt",   32'(if_gnt1), 1);
    check("sf_d_gnt",    32'(d_gnt1), 0);
    check("sf_mem_addr", 32'(mem_addr1), 32'h004);
    check("sf_mem_we",   32'(mem_we1), 0);
    step(); if_req = 0;
    @(negedge clk);
    check("sf_if_rvalid", 32'(if_rvalid1), 1);
    check("sf_if_rdata",  if_rdata1, 32'h0050_0093);
    check("sf_idle_req",  32'(mem_req1), 0);
    check("sf_idle_addr", 32'(mem_addr1), 0);
    step();
    @(negedge clk);
    check("sf_rvalid_one", 32'(if_rvalid1), 0);

    // Write acknowledge, then read back
    step(); d_req = 1; d_we = 1; d_addr = 12'h100; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_d_gnt",     32'(d_gnt1), 1);
    check("wr_mem_we",    32'(mem_we1), 1);
    check("wr_mem_addr",  32'(mem_addr1), 32'h100);
    check("wr_mem_wdata", mem_wdata1, 32'hDEAD_BEEF);
    step(); d_req = 0; d_we = 0; d_wdata = '0;
    @(negedge clk);
    check("wr_d_rvalid", 32'(d_rvalid1), 1);
    check("wr_d_rdata",  d_rdata1, 0);
    step(); d_req = 1; d_addr = 12'h100;
    @(negedge clk);
    check("rb_d_gnt", 32'(d_gnt1), 1);
    step(); d_req = 0;
    @(negedge clk);
    check("rb_d_rvalid", 32'(d_rvalid1), 1);
    check("rb_d_rdata",  d_rdata1, 32'hDEAD_BEEF);

    // Contested round-robin: D, F, D, F
    for (int k = 0; k < 4; k++) begin
      step(); if_req = 1; d_req = 1; if_addr = 12'h008; d_addr = 12'h00C;
      @(negedge clk);
      check($sformatf("rr%0d_d_gnt", k),     32'(d_gnt1), 32'((k % 2) == 0));
      check($sformatf("rr%0d_if_gnt", k),    32'(if_gnt1), 32'((k % 2) == 1));
      check($sformatf("rr%0d_cnt", k),       32'(cnt1), 32'(k));
      check($sformatf("rr%0d_d_rvalid", k),  32'(d_rvalid1), 32'((k % 2) == 1));
      check($sformatf("rr%0d_if_rvalid", k), 32'(if_rvalid1), 32'(k > 0 && (k % 2) == 0));
      if (k == 1) check("rr1_d_rdata", d_rdata1, 32'hA000_0003);
      if (k == 2) check("rr2_if_rdata", if_rdata1, 32'hA000_0002);
    end
    // Uncontested data grant must leave the pointer at FETCH
    step(); if_req = 0;
    @(negedge clk);
    check("uc_d_gnt",     32'(d_gnt1), 1);
    check("uc_if_rvalid", 32'(if_rvalid1), 1);
    check("uc_cnt",       32'(cnt1), 4);
    step(); if_req = 1;
    @(negedge clk);
    check("uc_next_d_gnt",  32'(d_gnt1), 1);
    check("uc_next_if_gnt", 32'(if_gnt1), 0);
    step(); if_req = 0; d_req = 0;
    @(negedge clk);
    check("uc_cnt_after", 32'(cnt1), 5);
    check("uc_d_rvalid",  32'(d_rvalid1), 1);

    // Latency 3: fetch in cycle 0, data held off until the response cycle
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    if_req = 1; if_addr = 12'h010;
    @(negedge clk);
    check("l3_if_gnt",   32'(if_gnt3), 1);
    check("l3_mem_addr", 32'(mem_addr3), 32'h010);
    step(); if_req = 0; d_req = 1; d_we = 0; d_addr = 12'h014;
    @(negedge clk);
    check("l3_c1_d_gnt",  32'(d_gnt3), 0);
    check("l3_c1_rvalid", 32'(if_rvalid3), 0);
    step();
    @(negedge clk);
    check("l3_c2_d_gnt", 32'(d_gnt3), 0);
    step();
    @(negedge clk);
    check("l3_c3_if_rvalid", 32'(if_rvalid3), 1);
    check("l3_c3_if_rdata",  if_rdata3, 32'hA000_0004);
    check("l3_c3_d_gnt",     32'(d_gnt3), 1);
    check("l3_c3_mem_addr",  32'(mem_addr3), 32'h014);
    step(); d_req = 0;
    @(negedge clk);
    check("l3_c4_d_rvalid", 32'(d_rvalid3), 0);
    check("l3_c4_cnt",      32'(cnt3), 0);
    step();
    @(negedge clk);
    check("l3_c5_d_rvalid", 32'(d_rvalid3), 0);
    step();
    @(negedge clk);
    check("l3_c6_d_rvalid", 32'(d_rvalid3), 1);
    check("l3_c6_d_rdata",  d_rdata3, 32'hA000_0005);

    // Reset in the middle of a latency-3 access
    step(); if_req = 1; if_addr = 12'h018;
    @(negedge clk);
    check("ra_if_gnt", 32'(if_gnt3), 1);
    step(); if_req = 0;
    #1 rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) step();
      if (c == 2) rst = 1'b0;
      @(negedge clk);
      check($sformatf("ra_c%0d_rvalid", c), 32'({if_rvalid3, d_rvalid3}), 0);
    end
    step(); if_req = 1; d_req = 1; if_addr = 12'h020; d_addr = 12'h024;
    @(negedge clk);
    check("ra_first_d_gnt",  32'(d_gnt3), 1);
    check("ra_first_if_gnt", 32'(if_gnt3), 0);
    step(); if_req = 0; d_req = 0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
